serial_add_sched: RTL and testbench
===================================

# serial_add_sched

Bit-serial addition scheduler that shares a single external full-adder cell (the team's `add` cell: sum plus carry) between two requesters. It arbitrates round-robin between two operand ports and steps the shared cell through the operand bits LSB-first, one bit per clock. It returns the WIDTH-bit sum and carry-out on a valid/ready response port. It sits between operand producers and the full-adder cell, replacing a WIDTH-cell ripple chain where area matters more than latency.

## Interface

- WIDTH, 4, operand/sum width in bits (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 operands valid
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_cin  in  1  requester 0 carry-in
- req1_valid / req1_ready / req1_a / req1_b / req1_cin: same for requester 1
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  index of requester that issued this result
- rsp_sum  out  WIDTH  sum
- rsp_cout  out  1  final carry-out
- fa_a, fa_b, fa_cin  out  1  drive to shared full-adder cell
- fa_sum, fa_cy_out  in  1  combinational returns from cell, sampled same cycle

One clock; reset is asynchronous and active-high.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Arbitrate between the requesters.
  - reqN_ready = (state==IDLE) && grant==N. This is combinational and asserted for the granted requester only.
  - Grant rule:
    - If only one valid is asserted, that requester is granted.
    - If both are asserted, the requester given priority by the priority pointer is granted.
  - On handshake:
    - Capture a, b, cin, and id.
    - Clear the bit index.
    - Set carry register := cin.
    - Move the priority pointer to the non-granted requester.
    - Go to RUN.
- RUN:
  - Drive fa_a = a[idx], fa_b = b[idx], fa_cin = carry.
  - At each edge, sum_reg[idx] := fa_sum, carry := fa_cy_out, and idx increments.
  - When idx==WIDTH-1 at the edge, go to DONE.
- DONE:
  - rsp_valid=1. rsp_sum = sum_reg, rsp_cout = carry, rsp_id = captured id.
  - All response outputs stay stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
- fa_* are 0 outside RUN.
- Requester valid must be held until ready. Operands are sampled only at the handshake edge, so later changes are ignored.
- Arithmetic: rsp_sum = (a + b + cin) mod 2^WIDTH; rsp_cout = bit WIDTH of the full sum.
- rsp_ready while rsp_valid is low is ignored.
- WIDTH=1: RUN lasts exactly one cycle.

## Timing

- Reset values:
  - state IDLE, priority pointer → req0.
  - idx 0, carry 0, sum_reg 0.
  - rsp_valid 0, rsp_id 0, rsp_sum 0, rsp_cout 0.
  - fa_* 0, req0_ready/req1_ready 0 while rst is high.
- Latency: with acceptance at edge E0, rsp_valid rises after edge E0+WIDTH (4 cycles for WIDTH=4).
- Minimum issue interval: WIDTH+2 cycles (one IDLE cycle, WIDTH RUN cycles, one DONE cycle with rsp_ready high).
- No new request is accepted in RUN or DONE; reqN_ready is 0 in those states.
- Backpressure: DONE is held indefinitely while rsp_ready=0.
- Reset mid-operation (RUN or DONE):
  - Immediate return to IDLE.
  - The in-flight result is discarded with no rsp_valid pulse.
  - Priority pointer returns to req0.
- Simultaneous valid on both ports: exactly one ready is asserted per IDLE cycle; never both.

## Test plan

- WIDTH=4, req0 a=4'hB, b=4'h6, cin=0 → rsp_sum=4'h1, rsp_cout=1, rsp_id=0; rsp_valid high exactly 4 cycles after the accept edge.
- req0 a=4'b0101, b=4'b0011, cin=0 → fa_a sequence 1,0,1,0; fa_b sequence 1,1,0,0; fa_cin sequence 0,1,1,1; result rsp_sum=4'h8, rsp_cout=0.
- Both valid from reset, rsp_ready=1:
  - req0 (3+4) is served first → rsp_sum 7, id 0.
  - Then req1 (F+0, cin=1) → rsp_sum 0, cout 1, id 1.
  - With both valid held, grants continue to alternate 0,1,0,1.
- rsp_ready held low 3 cycles in DONE → rsp_valid, rsp_sum, rsp_cout, rsp_id stable; req0_ready and req1_ready stay 0; IDLE is re-entered one cycle after rsp_ready rises.
- Assert rst during RUN at bit index 2 → next state IDLE, fa_* 0, no rsp_valid pulse; once rst is released, a pending req1 is granted only if req0 is not valid, because the pointer is back at req0.
- WIDTH=1 build: a=1, b=1, cin=1 → rsp_sum=1, rsp_cout=1, with rsp_valid one cycle after accept.

Source files
------------

// File: rtl/serial_add_sched.sv
// Bit-serial adder front end: two requesters share one external full-adder cell,
// which is stepped LSB-first, one bit per clock, with a valid/ready result port.
module serial_add_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cy_out
);

    // state | meaning
    // IDLE  | arbitrate requesters, accept one operand set
    // RUN   | drive one operand bit pair into the shared cell per clock
    // DONE  | hold result on the response port until rsp_ready
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int              IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]   LAST = IW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ptr;
    logic             r_id;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             w_grant;
    logic             w_accept;

    always_comb begin
        w_grant     = 1'b0;
        w_accept    = 1'b0;
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        fa_a        = 1'b0;
        fa_b        = 1'b0;
        fa_cin      = 1'b0;
        rsp_valid   = 1'b0;

        // Pointer only matters on a tie; a lone valid always wins.
        w_grant = (req0_valid && req1_valid) ? r_ptr : req1_valid;

        case (r_state)
            S_IDLE: begin
                w_accept   = !rst && (req0_valid || req1_valid);
                req0_ready = w_accept && !w_grant;
                req1_ready = w_accept && w_grant;
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                fa_a   = r_a[r_idx];
                fa_b   = r_b[r_idx];
                fa_cin = r_carry;
                if (r_idx == LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= 1'b0;
            r_id    <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_grant ? req1_a : req0_a;
                        r_b     <= w_grant ? req1_b : req0_b;
                        r_carry <= w_grant ? req1_cin : req0_cin;
                        r_id    <= w_grant;
                        r_idx   <= '0;
                        r_ptr   <= ~w_grant;
                    end
                end
                S_RUN: begin
                    r_sum[r_idx] <= fa_sum;
                    r_carry      <= fa_cy_out;
                    r_idx        <= r_idx + IW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_id   = r_id;
    assign rsp_sum  = r_sum;
    assign rsp_cout = r_carry;

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed bench for serial_add_sched: WIDTH=4 instance plus a WIDTH=1 instance,
// each with a behavioural full-adder cell on its fa_* port.
module tb_serial_add_sched;

    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_cin, req1_cin;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [3:0] rsp_sum;
    logic       fa_a, fa_b, fa_cin, fa_sum, fa_cy_out;

    logic       w1_valid, w1_ready, w1_a, w1_b, w1_cin;
    logic       w1_q_valid, w1_q_ready, w1_q_a, w1_q_b, w1_q_cin;
    logic       w1_rsp_valid, w1_rsp_ready, w1_rsp_id, w1_rsp_sum, w1_rsp_cout;
    logic       w1_fa_a, w1_fa_b, w1_fa_cin, w1_fa_sum, w1_fa_cy;

    int checks;
    int errors;

    serial_add_sched #(.WIDTH(4)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_sum(fa_sum), .fa_cy_out(fa_cy_out)
    );

    serial_add_sched #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst),
        .req0_valid(w1_valid), .req0_ready(w1_ready),
        .req0_a(w1_a), .req0_b(w1_b), .req0_cin(w1_cin),
        .req1_valid(w1_q_valid), .req1_ready(w1_q_ready),
        .req1_a(w1_q_a), .req1_b(w1_q_b), .req1_cin(w1_q_cin),
        .rsp_valid(w1_rsp_valid), .rsp_ready(w1_rsp_ready), .rsp_id(w1_rsp_id),
        .rsp_sum(w1_rsp_sum), .rsp_cout(w1_rsp_cout),
        .fa_a(w1_fa_a), .fa_b(w1_fa_b), .fa_cin(w1_fa_cin),
        .fa_sum(w1_fa_sum), .fa_cy_out(w1_fa_cy)
    );

    assign fa_sum    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cy_out = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
    assign w1_fa_sum = w1_fa_a ^ w1_fa_b ^ w1_fa_cin;
    assign w1_fa_cy  = (w1_fa_a & w1_fa_b) | (w1_fa_a & w1_fa_cin) | (w1_fa_b & w1_fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits (bounded) for rsp_valid, sampling 1 time unit after each edge.
    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req0_valid = 1'b1;
        w1_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || w1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got r0=%b r1=%b w1=%b want 0 0 0", req0_ready, req1_ready, w1_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 4'h0 || rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b sum=%h cout=%b id=%b want 0 0 0 0", rsp_valid, rsp_sum, rsp_cout, rsp_id);
        end
        checks++;
        if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
            errors++;
            $display("FAIL reset_fa: got %b want 000", {fa_a, fa_b, fa_cin});
        end
        req0_valid = 1'b0;
        w1_valid = 1'b0;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_basic;
        req0_a = 4'hB; req0_b = 4'h6; req0_cin = 1'b0;
        req0_valid = 1'b1;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_grant: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== (k == 4)) begin
                errors++;
                $display("FAIL basic_latency: edge+%0d got rsp_valid=%b want %b", k, rsp_valid, (k == 4));
            end
        end
        checks++;
        if (rsp_sum !== 4'h1 || rsp_cout !== 1'b1 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got sum=%h cout=%b id=%b want 1 1 0", rsp_sum, rsp_cout, rsp_id);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: got rsp_valid=%b want 0", rsp_valid);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_fa_seq;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        logic [3:0] exp_c;
        exp_a = 4'b0101;
        exp_b = 4'b0011;
        exp_c = 4'b1110;
        req0_a = 4'b0101; req0_b = 4'b0011; req0_cin = 1'b0;
        req0_valid = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fa_a !== exp_a[i] || fa_b !== exp_b[i] || fa_cin !== exp_c[i]) begin
                errors++;
                $display("FAIL fa_seq bit%0d: got a=%b b=%b cin=%b want %b %b %b",
                         i, fa_a, fa_b, fa_cin, exp_a[i], exp_b[i], exp_c[i]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 4'h8 || rsp_cout !== 1'b0) begin
            errors++;
            $display("FAIL fa_seq_result: got v=%b sum=%h cout=%b want 1 8 0", rsp_valid, rsp_sum, rsp_cout);
        end
        checks++;
        if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
            errors++;
            $display("FAIL fa_idle_done: got %b want 000", {fa_a, fa_b, fa_cin});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_round_robin;
        bit         ok;
        logic [3:0] exp_sum;
        logic       exp_cout;
        logic       exp_id;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req0_a = 4'h3; req0_b = 4'h4; req0_cin = 1'b0;
        req1_a = 4'hF; req1_b = 4'h0; req1_cin = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_id   = i[0];
            exp_sum  = exp_id ? 4'h0 : 4'h7;
            exp_cout = exp_id;
            checks++;
            if (req0_ready !== !exp_id || req1_ready !== exp_id) begin
                errors++;
                $display("FAIL rr_grant%0d: got r0=%b r1=%b want %b %b", i, req0_ready, req1_ready, !exp_id, exp_id);
            end
            wait_rsp(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rr_timeout%0d: got no rsp_valid want rsp_valid=1", i);
            end else if (rsp_sum !== exp_sum || rsp_cout !== exp_cout || rsp_id !== exp_id) begin
                errors++;
                $display("FAIL rr_result%0d: got sum=%h cout=%b id=%b want %h %b %b",
                         i, rsp_sum, rsp_cout, rsp_id, exp_sum, exp_cout, exp_id);
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        bit ok;
        req0_a = 4'h1; req0_b = 4'h2; req0_cin = 1'b0;
        req0_valid = 1'b1;
        @(posedge clk); #1;
        req1_valid = 1'b1;
        wait_rsp(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_timeout: got no rsp_valid want rsp_valid=1");
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_sum !== 4'h3 || rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b sum=%h cout=%b id=%b want 1 3 0 0",
                         c, rsp_valid, rsp_sum, rsp_cout, rsp_id);
            end
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready%0d: got r0=%b r1=%b want 0 0", c, req0_ready, req1_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_reenter: got v=%b r0=%b r1=%b want 0 0 1", rsp_valid, req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid;
        req0_a = 4'hF; req0_b = 4'hF; req0_cin = 1'b1;
        req0_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({fa_a, fa_b, fa_cin} !== 3'b111) begin
            errors++;
            $display("FAIL rmid_bit2: got %b want 111", {fa_a, fa_b, fa_cin});
        end
        req1_valid = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if ({fa_a, fa_b, fa_cin} !== 3'b000 || rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_abort: got fa=%b v=%b r0=%b r1=%b want 000 0 0 0",
                     {fa_a, fa_b, fa_cin}, rsp_valid, req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b1;
        rst = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_ptr: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_lone: got r0=%b r1=%b want 0 1", req0_ready, req1_ready);
        end
        req1_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rmid_nopulse%0d: got rsp_valid=%b want 0", c, rsp_valid);
            end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_width1;
        w1_a = 1'b1; w1_b = 1'b1; w1_cin = 1'b1;
        w1_valid = 1'b1;
        w1_rsp_ready = 1'b0;
        #1;
        checks++;
        if (w1_ready !== 1'b1) begin
            errors++;
            $display("FAIL w1_grant: got ready=%b want 1", w1_ready);
        end
        @(posedge clk); #1;
        w1_valid = 1'b0;
        checks++;
        if (w1_rsp_valid !== 1'b0 || {w1_fa_a, w1_fa_b, w1_fa_cin} !== 3'b111) begin
            errors++;
            $display("FAIL w1_run: got v=%b fa=%b want 0 111", w1_rsp_valid, {w1_fa_a, w1_fa_b, w1_fa_cin});
        end
        @(posedge clk); #1;
        checks++;
        if (w1_rsp_valid !== 1'b1 || w1_rsp_sum !== 1'b1 || w1_rsp_cout !== 1'b1 || w1_rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL w1_result: got v=%b sum=%b cout=%b id=%b want 1 1 1 0",
                     w1_rsp_valid, w1_rsp_sum, w1_rsp_cout, w1_rsp_id);
        end
        w1_rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (w1_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL w1_release: got v=%b want 0", w1_rsp_valid);
        end
        w1_rsp_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        rsp_ready = 1'b0;
        w1_valid = 1'b0; w1_a = 1'b0; w1_b = 1'b0; w1_cin = 1'b0;
        w1_q_valid = 1'b0; w1_q_a = 1'b0; w1_q_b = 1'b0; w1_q_cin = 1'b0;
        w1_rsp_ready = 1'b0;
        @(posedge clk); #1;

        test_reset();
        test_basic();
        test_fa_seq();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_width1();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
